// File: rtl/aexm_regf_mt_if.sv
// Decode/execute <-> register file bus for the multi-thread aexm register file.
// Thread-ID fields are held at one bit when TW=0 and are then ignored by the register file.
interface aexm_regf_mt_if #(
  parameter int TW = 1
);
  localparam int TIDW = (TW == 0) ? 1 : TW;

  logic            gena;
  logic [TIDW-1:0] rTID;
  logic [TIDW-1:0] rWTID;
  logic [4:0]      rRA;
  logic [4:0]      rRB;
  logic [4:0]      rRD;
  logic [4:0]      rRW;
  logic [1:0]      rMXDST;
  logic [31:0]     rRESULT;
  logic [29:0]     rPCLNK;
  logic [3:0]      rDWBSEL;
  logic [1:0]      rOPC;
  logic            rLDSGN;
  logic [31:0]     aexm_dcache_datai;
  logic [31:0]     rREGA;
  logic [31:0]     rREGB;
  logic [31:0]     rDWBDI;
  logic [31:0]     aexm_dcache_datao;
  logic            clr_busy;

  modport master (
    output gena, rTID, rWTID, rRA, rRB, rRD, rRW, rMXDST, rRESULT, rPCLNK,
           rDWBSEL, rOPC, rLDSGN, aexm_dcache_datai,
    input  rREGA, rREGB, rDWBDI, aexm_dcache_datao, clr_busy
  );

  modport slave (
    input  gena, rTID, rWTID, rRA, rRB, rRD, rRW, rMXDST, rRESULT, rPCLNK,
           rDWBSEL, rOPC, rLDSGN, aexm_dcache_datai,
    output rREGA, rREGB, rDWBDI, aexm_dcache_datao, clr_busy
  );
endinterface

// File: rtl/aexm_regf_mt.sv
// Multi-thread register file: 2**TW banks of 32x32, load sizer, registered store sizer, clear sweep.
// Define AEXM_REGF_SEXT_EN to enable sign-extended byte/half loads via rLDSGN.
module aexm_regf_mt #(
  parameter int TW = 1
) (
  input logic           gclk,
  input logic           grst,
  aexm_regf_mt_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int TIDW   = (TW == 0) ? 1 : TW;
  localparam int AW     = 5 + TW;
  localparam int DEPTH  = 32 << TW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              norm_we_p0, rdy_we_p0, fwd_p0, we_p0, ld_sgn_p0;
  logic [AW-1:0]     wa_p0, norm_wa_p0, ra_p0, rb_p0, rd_p0;
  logic [DATA_W-1:0] wd_p0, norm_wd_p0, st_src_p0;
  logic [DATA_W-1:0] dato_p1;

  // With TW=0 the shifted thread field falls off the top, leaving a single bank.
  function automatic logic [AW-1:0] ram_addr(input logic [TIDW-1:0] tid, input logic [4:0] r);
    return (AW'(tid) << 5) | AW'(r);
  endfunction

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = b;
    return sgn ? DATA_W'(sb) : {24'b0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = h;
    return sgn ? DATA_W'(sh) : {16'b0, h};
  endfunction

  function automatic logic [DATA_W-1:0] load_size(input logic [31:0] d, input logic [3:0] sel,
                                                  input logic sgn);
    case (sel)
      4'h8:    return ext8(d[31:24], sgn);
      4'h4:    return ext8(d[23:16], sgn);
      4'h2:    return ext8(d[15:8], sgn);
      4'h1:    return ext8(d[7:0], sgn);
      4'hC:    return ext16(d[31:16], sgn);
      4'h3:    return ext16(d[15:0], sgn);
      4'hF:    return d;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_size(input logic [31:0] w, input logic [1:0] opc);
    case (opc)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      2'd2:    return w;
      default: return '0;
    endcase
  endfunction

`ifdef AEXM_REGF_SEXT_EN
  assign ld_sgn_p0 = bus.rLDSGN;
`else
  assign ld_sgn_p0 = 1'b0;
`endif

  // Stage p0: combinational reads, load sizing, write-port selection and store source.
  assign ra_p0 = ram_addr(bus.rTID, bus.rRA);
  assign rb_p0 = ram_addr(bus.rTID, bus.rRB);
  assign rd_p0 = ram_addr(bus.rTID, bus.rRD);

  assign bus.rREGA  = mem[ra_p0];
  assign bus.rREGB  = mem[rb_p0];
  assign bus.rDWBDI = load_size(bus.aexm_dcache_datai, bus.rDWBSEL, ld_sgn_p0);

  assign norm_we_p0 = bus.gena && (bus.rRW != 5'd0) && (bus.rMXDST != 2'd3);
  assign norm_wa_p0 = ram_addr(bus.rWTID, bus.rRW);
  assign rdy_we_p0  = (state_q == READY) && norm_we_p0;

  always_comb begin
    norm_wd_p0 = bus.rRESULT;
    case (bus.rMXDST)
      2'd1:    norm_wd_p0 = {bus.rPCLNK, 2'b00};
      2'd2:    norm_wd_p0 = bus.rDWBDI;
      default: norm_wd_p0 = bus.rRESULT;
    endcase
  end

  // Comparing full RAM addresses covers both the thread and register match.
  assign fwd_p0    = rdy_we_p0 && (norm_wa_p0 == rd_p0);
  assign st_src_p0 = fwd_p0 ? norm_wd_p0 : mem[rd_p0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_p0   = 1'b0;
    wa_p0   = norm_wa_p0;
    wd_p0   = norm_wd_p0;
    if (state_q == CLEAR) begin
      we_p0 = 1'b1;
      wa_p0 = cnt_q;
      wd_p0 = '0;
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) state_d = READY;
    end else begin
      we_p0 = norm_we_p0;
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst && we_p0) mem[wa_p0] <= wd_p0;
  end

  // Stage p1: registered store data toward the dcache.
  always_ff @(posedge gclk) begin
    if (!grst)         dato_p1 <= '0;
    else if (bus.gena) dato_p1 <= store_size(st_src_p0, bus.rOPC);
  end

  assign bus.aexm_dcache_datao = dato_p1;
  assign bus.clr_busy          = (state_q == CLEAR);
endmodule

// File: tb/tb_aexm_regf_mt.sv
// Directed bench for aexm_regf_mt (TW=1): expectations queued as stimulus is applied, checked on output.
// Load-sizer expectations follow AEXM_REGF_SEXT_EN when the bench is built with it.
module tb_aexm_regf_mt;
  localparam int TW = 1;

  logic gclk = 1'b0;
  logic grst;

  aexm_regf_mt_if #(.TW(TW)) bus();

  aexm_regf_mt #(.TW(TW)) dut (
    .gclk(gclk),
    .grst(grst),
    .bus (bus)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required <queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic wr(input logic tid, input logic [4:0] r, input logic [31:0] v, input logic [1:0] mx);
    bus.rWTID   = tid;
    bus.rRW     = r;
    bus.rRESULT = v;
    bus.rMXDST  = mx;
    bus.gena    = 1'b1;
    tick();
    bus.gena    = 1'b0;
    bus.rMXDST  = 2'd3;
  endtask

  task automatic rd_a(input logic tid, input logic [4:0] r);
    bus.rTID = tid;
    bus.rRA  = r;
    #1;
  endtask

  logic [3:0]  ld_sel [8] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF, 4'h5};
`ifdef AEXM_REGF_SEXT_EN
  logic [31:0] ld_exp [8] = '{32'hFFFFFF80, 32'hFFFFFFF1, 32'hFFFFFFA2, 32'hFFFFFFB3,
                              32'hFFFF80F1, 32'hFFFFA2B3, 32'h80F1A2B3, 32'h00000000};
`else
  logic [31:0] ld_exp [8] = '{32'h00000080, 32'h000000F1, 32'h000000A2, 32'h000000B3,
                              32'h000080F1, 32'h0000A2B3, 32'h80F1A2B3, 32'h00000000};
`endif

  int n;

  initial begin
    grst = 1'b0;
    bus.gena = 1'b0;
    bus.rTID = '0;
    bus.rWTID = '0;
    bus.rRA = '0;
    bus.rRB = '0;
    bus.rRD = '0;
    bus.rRW = '0;
    bus.rMXDST = 2'd3;
    bus.rRESULT = '0;
    bus.rPCLNK = '0;
    bus.rDWBSEL = 4'h0;
    bus.rOPC = 2'd2;
    bus.rLDSGN = 1'b0;
    bus.aexm_dcache_datai = '0;

    // Reset for three cycles, then the full clear sweep.
    repeat (3) tick();
    push("rst_clr_busy", 32'd1);
    check(32'(bus.clr_busy));
    push("rst_datao", 32'h0);
    check(bus.aexm_dcache_datao);

    grst = 1'b1;
    n = 0;
    while (bus.clr_busy && n < 200) begin
      tick();
      n++;
    end
    push("clear_len", 32'd64);
    check(32'(n));

    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++) begin
        bus.rTID = t[0];
        bus.rRA  = r[4:0];
        bus.rRB  = 5'(31 - r);
        #1;
        push("clr_rega", 32'h0);
        check(bus.rREGA);
        push("clr_regb", 32'h0);
        check(bus.rREGB);
        tick();
      end
    end
    push("clr_datao", 32'h0);
    check(bus.aexm_dcache_datao);

    // Bank isolation.
    wr(1'b0, 5'd5, 32'hDEADBEEF, 2'd0);
    wr(1'b1, 5'd5, 32'h12345678, 2'd0);
    rd_a(1'b0, 5'd5);
    push("bank0_r5", 32'hDEADBEEF);
    check(bus.rREGA);
    rd_a(1'b1, 5'd5);
    push("bank1_r5", 32'h12345678);
    check(bus.rREGA);
    bus.rRB = 5'd5;
    #1;
    push("bank1_r5_b", 32'h12345678);
    check(bus.rREGB);
    tick();

    // r0 stays zero; rMXDST=3 does not write.
    wr(1'b0, 5'd7, 32'h00007777, 2'd0);
    wr(1'b0, 5'd0, 32'hFFFFFFFF, 2'd0);
    wr(1'b0, 5'd7, 32'hFFFFFFFF, 2'd3);
    rd_a(1'b0, 5'd0);
    push("r0_zero", 32'h0);
    check(bus.rREGA);
    rd_a(1'b0, 5'd7);
    push("r7_kept", 32'h00007777);
    check(bus.rREGA);
    tick();

    // Link and load-data write sources.
    bus.rPCLNK = 30'h01234567;
    wr(1'b1, 5'd10, 32'h0, 2'd1);
    bus.aexm_dcache_datai = 32'h80F1A2B3;
    bus.rDWBSEL = 4'hC;
    bus.rLDSGN = 1'b0;
    wr(1'b1, 5'd11, 32'h0, 2'd2);
    rd_a(1'b1, 5'd10);
    push("link_wr", 32'h048D159C);
    check(bus.rREGA);
    rd_a(1'b1, 5'd11);
    push("load_wr", 32'h000080F1);
    check(bus.rREGA);
    tick();

    // Load sizer, signed request then unsigned.
    bus.rLDSGN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rDWBSEL = ld_sel[i];
      #1;
      push("ld_size", ld_exp[i]);
      check(bus.rDWBDI);
      tick();
    end
    bus.rLDSGN = 1'b0;
    bus.rDWBSEL = 4'h8;
    #1;
    push("ld_b3_zext", 32'h00000080);
    check(bus.rDWBDI);
    bus.rDWBSEL = 4'h4;
    #1;
    push("ld_b2_zext", 32'h000000F1);
    check(bus.rDWBDI);
    tick();

    // Store forwarding from a same-cycle write, then hold with gena=0.
    bus.rTID = 1'b0;
    bus.rRD  = 5'd9;
    bus.rOPC = 2'd0;
    wr(1'b0, 5'd9, 32'h000000AB, 2'd0);
    push("st_fwd_byte", 32'hABABABAB);
    check(bus.aexm_dcache_datao);
    bus.rRD  = 5'd5;
    bus.rOPC = 2'd2;
    tick();
    push("st_hold", 32'hABABABAB);
    check(bus.aexm_dcache_datao);
    rd_a(1'b0, 5'd9);
    push("r9_visible", 32'h000000AB);
    check(bus.rREGA);
    tick();

    // Store sizes from the register array.
    bus.rTID = 1'b1;
    bus.rRD  = 5'd5;
    bus.gena = 1'b1;
    bus.rOPC = 2'd1;
    tick();
    push("st_half", 32'h56785678);
    check(bus.aexm_dcache_datao);
    bus.rOPC = 2'd2;
    tick();
    push("st_word", 32'h12345678);
    check(bus.aexm_dcache_datao);
    bus.rOPC = 2'd3;
    tick();
    push("st_illegal", 32'h0);
    check(bus.aexm_dcache_datao);
    bus.gena = 1'b0;

    // A write to another thread's r9 must not forward.
    bus.rTID = 1'b0;
    bus.rRD  = 5'd9;
    bus.rOPC = 2'd2;
    wr(1'b1, 5'd9, 32'h00000011, 2'd0);
    push("st_no_fwd_tid", 32'h000000AB);
    check(bus.aexm_dcache_datao);

    // Reset at clear cycle 20 restarts the sweep; writes during clear are dropped.
    grst = 1'b0;
    tick();
    grst = 1'b1;
    repeat (20) tick();
    push("mid_clr_busy", 32'd1);
    check(32'(bus.clr_busy));
    grst = 1'b0;
    tick();
    push("mid_rst_datao", 32'h0);
    check(bus.aexm_dcache_datao);
    grst = 1'b1;
    n = 0;
    while (bus.clr_busy && n < 200) begin
      if (n == 39) begin
        bus.gena    = 1'b1;
        bus.rWTID   = 1'b0;
        bus.rRW     = 5'd1;
        bus.rMXDST  = 2'd0;
        bus.rRESULT = 32'h0000CAFE;
        bus.rRD     = 5'd0;
      end else begin
        bus.gena   = 1'b0;
        bus.rMXDST = 2'd3;
      end
      tick();
      n++;
    end
    bus.gena = 1'b0;
    bus.rMXDST = 2'd3;
    push("reclear_len", 32'd64);
    check(32'(n));
    rd_a(1'b0, 5'd1);
    push("clr_drops_wr", 32'h0);
    check(bus.rREGA);
    rd_a(1'b1, 5'd5);
    push("reclear_b1r5", 32'h0);
    check(bus.rREGA);
    rd_a(1'b0, 5'd9);
    push("reclear_b0r9", 32'h0);
    check(bus.rREGA);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aexm_regf_mt.md
# aexm_regf_mt

Multi-thread general-purpose register file for the aexm core, the parametrised successor of the single-context register file. It holds 2**TW independent banks of 32 x 32-bit registers, with two asynchronous read ports, one write port, load-data sizing with optional sign extension, and a registered store-data sizer toward the data cache. A post-reset clear sequencer zeroes every bank, since the distributed RAM has no reset. The block sits between decode/execute and the dcache interface.

## Interface
- TW, 1: thread-ID width; bank count NTH = 2**TW; legal values 0..3.
- gclk  in  1  core clock; all state updates on its rising edge.
- grst  in  1  reset, synchronous, active-low.
- gena  in  1  pipeline enable; gates normal writes and the store register.
- rTID  in  TW  thread selecting the bank for the rRA/rRB/rRD reads (width forced to 1 when TW=0; ignored).
- rWTID  in  TW  thread selecting the bank for the write port.
- rRA, rRB, rRD, rRW  in  5  read A, read B, store-source and write register indices.
- rMXDST  in  2  write source: 0 rRESULT, 1 {rPCLNK,2'b00}, 2 sized load data, 3 no write.
- rRESULT  in  32  ALU result.
- rPCLNK  in  30  link address [31:2].
- rDWBSEL  in  4  load byte lanes.
- rOPC  in  2  store size: 0 byte, 1 half, 2 word, 3 illegal.
- rLDSGN  in  1  signed-load request (used only with AEXM_REGF_SEXT_EN).
- aexm_dcache_datai  in  32  raw load data.
- rREGA, rREGB  out  32  asynchronous reads of bank rTID.
- rDWBDI  out  32  sized load data (combinational).
- aexm_dcache_datao  out  32  registered store data.
- clr_busy  out  1  high while the clear sequencer runs.

## Operation
- Address into RAM = {bank, reg}; depth 32*NTH.
- Clear FSM, states CLEAR and READY. grst=0 at an edge: state<=CLEAR, counter<=0, aexm_dcache_datao<=0. In CLEAR (grst=1): write 0 at address counter each cycle regardless of gena; counter increments; on counter = 32*NTH-1, write it and go READY. clr_busy = (state==CLEAR); it reads 1 from the first reset edge onward.
- Reset during CLEAR restarts the sweep at 0. Normal writes are discarded in CLEAR.
- READY: write when gena=1, rRW!=0, rMXDST!=3; data per rMXDST. Register 0 of every bank stays 0.
- Load sizer, by rDWBSEL: 8/4/2/1 select byte [31:24]/[23:16]/[15:8]/[7:0]; C/3 select half [31:16]/[15:0]; F full word; any other code gives 0.
- Store source forwarding: if a READY write is active, rWTID==rTID and rRW==rRD, the source is the write data; otherwise bank rTID, register rRD.
- Store sizer: rOPC 0 replicates byte [7:0] x4, 1 replicates half [15:0] x2, 2 passes the word, 3 gives 0.
- Read ports do not forward; a same-cycle write becomes visible the next cycle.

## Timing
- rREGA, rREGB and rDWBDI are combinational, with zero latency.
- aexm_dcache_datao has 1-cycle latency and is updated only on edges where gena=1 and grst=1; it holds otherwise.
- The clear takes exactly 32*NTH cycles after grst rises. clr_busy falls on the edge that writes the last address.
- A write is visible on the read ports the cycle after the enabling edge.

## Configuration
- AEXM_REGF_SEXT_EN defined: when rLDSGN=1, byte and half loads are sign-extended from bit 7 or bit 15. When rLDSGN=0, they are zero-extended.
- Without the macro: all loads are zero-extended. rLDSGN is ignored and must remain an unused port.

## Test plan
- Reset then clear, TW=1: hold grst=0 for 3 cycles, then release -> clr_busy=1 for exactly 64 cycles. Afterwards every register reads 0, and aexm_dcache_datao=0.
- Bank isolation: write 0xDEADBEEF to r5 of thread 0 and 0x12345678 to r5 of thread 1 -> rREGA with rTID=0, rRA=5 gives 0xDEADBEEF; with rTID=1 it gives 0x12345678.
- R0/no-write: rRW=0 with rRESULT=0xFFFFFFFF, then rMXDST=3 with rRW=7 -> r0 stays 0, and r7 keeps its prior value.
- Load sizer: datai=0x80F1A2B3 -> rDWBSEL=8 gives 0x00000080 (0xFFFFFF80 with the macro and rLDSGN=1). rDWBSEL=3 gives 0x0000A2B3. rDWBSEL=5 gives 0.
- Store forward: a same-cycle write of rRESULT=0x000000AB to r9, with rRD=9 and rOPC=0 -> next cycle aexm_dcache_datao=0xABABABAB. With gena=0 on the following cycle, it holds 0xABABABAB.
- Reset mid-clear: pull grst low at clear cycle 20 -> the counter restarts, and clr_busy stays high for a full 64 cycles after release.
